// File: rtl/mux8x1_reg_pkg.sv
// mux8x1_reg_pkg: shared constants for the registered 8:1 selector.
package mux8x1_reg_pkg;
  localparam int SEL_W = 3;
endpackage

// File: rtl/mux4_stage.sv
// mux4_stage: combinational 4:1 selector, one leaf of the 8:1 tree.
module mux4_stage #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
  end
endmodule

// File: rtl/mux8x1_reg.sv
// mux8x1_reg: 8:1 selector built from two 4:1 stages and a 2:1 stage, registered output with valid.
module mux8x1_reg
  import mux8x1_reg_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);
  logic [WIDTH-1:0] lower, upper, mux_d, out_d, out_q;
  logic             out_valid_d, out_valid_q;
  mux4_stage #(.WIDTH(WIDTH)) u_lower (
    .d0(i0), .d1(i1), .d2(i2), .d3(i3), .sel(sel[1:0]), .y(lower)
  );
  mux4_stage #(.WIDTH(WIDTH)) u_upper (
    .d0(i4), .d1(i5), .d2(i6), .d3(i7), .sel(sel[1:0]), .y(upper)
  );
  always_comb begin
    mux_d       = sel[SEL_W-1] ? upper : lower;
    out_d       = in_valid ? mux_d : out_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out       = out_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mux8x1_reg.sv
// tb_mux8x1_reg: randomized self-checking bench for WIDTH=8 and WIDTH=1 instances of mux8x1_reg.
module tb_mux8x1_reg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d [8];
  logic [7:0] bits;
  logic [2:0] sel;
  logic       in_valid;
  logic [7:0] out8;
  logic       out1, v8, v1;
  logic [7:0] exp8;
  logic       exp1, expv;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  mux8x1_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .i0(d[0]), .i1(d[1]), .i2(d[2]), .i3(d[3]),
    .i4(d[4]), .i5(d[5]), .i6(d[6]), .i7(d[7]),
    .sel(sel), .in_valid(in_valid), .out(out8), .out_valid(v8)
  );

  mux8x1_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .i0(bits[0]), .i1(bits[1]), .i2(bits[2]), .i3(bits[3]),
    .i4(bits[4]), .i5(bits[5]), .i6(bits[6]), .i7(bits[7]),
    .sel(sel), .in_valid(in_valid), .out(out1), .out_valid(v1)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic randomize_inputs(input bit rand_valid);
    for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
    bits     = 8'($urandom);
    sel      = 3'($urandom);
    in_valid = rand_valid ? 1'($urandom) : 1'b1;
  endtask

  // Reference: one register stage holding the last selected word, valid follows in_valid.
  task automatic cycle();
    if (in_valid) begin
      exp8 = d[sel];
      exp1 = bits[sel];
    end
    expv = in_valid;
    @(posedge clk); #1;
    chk("out8", out8, exp8);
    chk("valid8", 8'(v8), 8'(expv));
    chk("out1", 8'(out1), 8'(exp1));
    chk("valid1", 8'(v1), 8'(expv));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_out8"}, out8, 8'h00);
    chk({tag, "_v8"}, 8'(v8), 8'h00);
    chk({tag, "_out1"}, 8'(out1), 8'h00);
    chk({tag, "_v1"}, 8'(v1), 8'h00);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] walk;
    randomize_inputs(1'b0);
    for (int c = 0; c < 3; c++) begin
      randomize_inputs(1'b0);
      @(posedge clk); #1;
      check_cleared("rst");
    end
    rst_n = 1'b1;
    #2;
    check_cleared("rst_rel");
    exp8 = 8'h00; exp1 = 1'b0; expv = 1'b0;

    pat = 8'b1011_0010;
    bits = pat;
    in_valid = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cycle();
      chk("sweep1", 8'(out1), 8'(pat[s]));
    end

    for (int k = 0; k < 8; k++) d[k] = 8'h01 << k;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cycle();
      walk = 8'h01 << s;
      chk("walk8", out8, walk);
    end

    sel = 3'd5; d[5] = 8'hA5; in_valid = 1'b1;
    cycle();
    chk("hold_cap", out8, 8'hA5);
    d[5] = 8'h3C; in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cycle();
      chk("hold_out", out8, 8'hA5);
      chk("hold_v", 8'(v8), 8'h00);
    end

    for (int c = 0; c < 1000; c++) begin
      randomize_inputs(1'b1);
      cycle();
    end

    for (int k = 0; k < 8; k++) d[k] = 8'hFF;
    bits = 8'hFF; in_valid = 1'b1;
    cycle();
    chk("pre_rst_out", out8, 8'hFF);
    #2 rst_n = 1'b0;
    #1 check_cleared("mid_rst");
    randomize_inputs(1'b0);
    @(posedge clk); #1;
    check_cleared("mid_rst_hold");
    rst_n = 1'b1;
    #1 check_cleared("mid_rst_rel");
    exp8 = 8'h00; exp1 = 1'b0; expv = 1'b0;
    randomize_inputs(1'b0);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mux8x1_reg.md
Name: mux8x1_reg

Overview:
- 8-to-1 selector with a registered output, WIDTH bits per data input.
- Chooses one of i0..i7 by the 3-bit select and presents it one clock later, with a qualifying valid flag.
- Built as a two-level tree: two 4:1 stages on sel[1:0], then a 2:1 stage on sel[2].
- Used wherever a small registered data-path selector is needed; the WIDTH=1 instance is the bit-level mux.

Parameters:
- WIDTH, 1, bit width of each data input and of out.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- i0  input  WIDTH  data input selected when sel=0.
- i1  input  WIDTH  data input selected when sel=1.
- i2  input  WIDTH  data input selected when sel=2.
- i3  input  WIDTH  data input selected when sel=3.
- i4  input  WIDTH  data input selected when sel=4.
- i5  input  WIDTH  data input selected when sel=5.
- i6  input  WIDTH  data input selected when sel=6.
- i7  input  WIDTH  data input selected when sel=7.
- sel  input  3  unsigned select, 0..7.
- in_valid  input  1  qualifies i0..i7 and sel this cycle.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  out holds a freshly captured selection.

Behaviour:
- Reset:
  - rst_n low forces out=0 and out_valid=0 immediately, independent of clk.
  - Both outputs hold those values while rst_n is low.
  - On deassertion, capture resumes at the first rising clk edge.
- Combinational select:
  - sel_lo=sel[1:0] chooses lower = {i0,i1,i2,i3}[sel_lo] and upper = {i4,i5,i6,i7}[sel_lo].
  - sel[2]=0 picks lower; sel[2]=1 picks upper.
  - Net result: mux_d = i[sel] for every sel value 0..7. No out-of-range case exists.
- Register stage, on each rising clk edge with rst_n high:
  - If in_valid=1: out <= mux_d and out_valid <= 1.
  - If in_valid=0: out holds its previous value and out_valid <= 0.
- Latency and throughput:
  - Latency is exactly 1 cycle from the input sample edge to out/out_valid.
  - One result per cycle. No backpressure, no stall.
- Changing sel or data every cycle is legal; each valid cycle is captured independently.
- X on sel with in_valid=1 is a usage error. out may go X; out_valid still goes 1.
- Reset asserted mid-stream discards any pending capture. The first post-reset out_valid comes one cycle after the first valid input.
- No internal state beyond the out and out_valid flops.

Decomposition:
- Shared package: no typedefs needed. A localparam SEL_W=3 for the select width may be placed there.
- One natural sub-module, mux4_stage (parameter WIDTH): four WIDTH-bit inputs, 2-bit sel, combinational output.
- Instantiate mux4_stage twice (lower group, upper group).
- The final 2:1 stage and the output registers sit in the top level.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 and random data -> out=0, out_valid=0 throughout. Release rst_n=1 asynchronously mid-cycle -> outputs stay 0 until the next edge.
- Exhaustive select, WIDTH=1: set i0..i7=8'b1011_0010 (i0=0, i1=1, i2=0, i3=0, i4=1, i5=1, i6=0, i7=1); sweep sel 0..7 with in_valid=1 -> out one cycle later equals i[sel]. Sequence is 0,1,0,0,1,1,0,1, with out_valid=1 each cycle.
- Walking-one, WIDTH=8: set ik=8'h01<<k; sweep sel 0..7 -> out=8'h01,02,04,08,10,20,40,80 at latency 1.
- Hold on invalid: capture sel=5, i5=8'hA5. Then drive in_valid=0 with i5=8'h3C for 2 cycles -> out stays 8'hA5 and out_valid=0 for both cycles.
- Random regression: 1000 cycles of random data, sel and in_valid -> out and out_valid match a 1-cycle-delayed reference model on every cycle.
- Async reset mid-stream: assert rst_n=0 between edges while out=8'hFF and out_valid=1 -> both clear before the next edge. After release, the first valid input appears at out exactly one edge later.
